// File: rtl/tinyml_pkg.sv
// Shared types for the tinyml execution-unit datapath: element/tile geometry and buffer ids.
package tinyml_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int TILE_ELEMS = 32;

  typedef logic signed [DATA_WIDTH-1:0] [0:TILE_ELEMS-1] tile_t;
  typedef logic [4:0] buf_id_t;

endpackage

// File: rtl/tile_fifo.sv
// Synchronous FIFO of tiles; a push is accepted while full when a pop happens in the same cycle.
module tile_fifo
  import tinyml_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  tile_t                      din,
  input  logic                       pop,
  output tile_t                      dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  tile_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vec_tile_streamer.sv
// Vector read initiator: issues one read per tile under FIFO credit, buffers the fixed-latency
// returns and streams them out with LAST on the final tile of each command.
//
// state  | meaning
// IDLE   | waiting for a command (cmd_ready high once the post-reset flush window ends)
// ISSUE  | issuing rd_en while tiles remain and FIFO credit is available
// DRAIN  | all reads issued; waiting for returns and the last output handshake
// FINISH | one-cycle done pulse, then back to IDLE
module vec_tile_streamer
  import tinyml_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  buf_id_t              cmd_buf_id,
  input  logic [CNT_WIDTH-1:0] cmd_num_tiles,
  output logic                 rd_en,
  output buf_id_t              rd_buf_id,
  input  tile_t                rd_tile,
  input  logic                 rd_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output tile_t                out_tile,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 protocol_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(READ_LATENCY + 1);

  state_t                state, state_nx;
  logic [CNT_WIDTH-1:0]  num_tiles, issued, delivered;
  logic [CW-1:0]         inflight, fifo_count;
  logic [FW-1:0]         flush_cnt;
  logic                  fifo_full, fifo_empty;
  logic                  accept, ret_ok, pop, last_hs, credit_ok;
  tile_t                 fifo_dout;

  // Returns still in the controller pipe when reset hit arrive with inflight==0; the flush
  // window swallows them silently and holds off new commands so they cannot be misattributed.
  assign cmd_ready = (state == IDLE) && (flush_cnt == '0);
  assign accept    = cmd_valid && cmd_ready;
  assign credit_ok = !fifo_full &&
                     ((CW+1)'(fifo_count) + (CW+1)'(inflight) < (CW+1)'(FIFO_DEPTH));
  assign rd_en     = (state == ISSUE) && (issued < num_tiles) && credit_ok;
  assign ret_ok    = rd_valid && (inflight != '0);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_tile  = out_valid ? fifo_dout : '0;
  assign out_last  = out_valid && (delivered == num_tiles - CNT_WIDTH'(1));
  assign last_hs   = pop && out_last;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

  tile_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_ok),
    .din   (rd_tile),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept) state_nx = (cmd_num_tiles == '0) ? FINISH : ISSUE;
      ISSUE:  if (issued == num_tiles) state_nx = DRAIN;
      DRAIN:  if ((inflight == '0) && (last_hs || ((delivered == num_tiles) && fifo_empty)))
                state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      num_tiles    <= '0;
      rd_buf_id    <= '0;
      issued       <= '0;
      delivered    <= '0;
      inflight     <= '0;
      protocol_err <= 1'b0;
      flush_cnt    <= FW'(READ_LATENCY);
    end else begin
      state <= state_nx;
      if (flush_cnt != '0) flush_cnt <= flush_cnt - FW'(1);
      if (accept) begin
        num_tiles <= cmd_num_tiles;
        rd_buf_id <= cmd_buf_id;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (rd_en) issued    <= issued + CNT_WIDTH'(1);
        if (pop)   delivered <= delivered + CNT_WIDTH'(1);
      end
      case ({rd_en, ret_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (rd_valid && (inflight == '0) && (flush_cnt == '0)) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_tile_streamer.sv
// Directed and randomized bench for vec_tile_streamer with a fixed-latency controller model
// and a per-command expected tile stream derived from (buffer id, tile index).
module tb_vec_tile_streamer;
  import tinyml_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  buf_id_t     cmd_buf_id = '0;
  logic [15:0] cmd_num_tiles = '0;
  logic        rd_en;
  buf_id_t     rd_buf_id;
  tile_t       rd_tile = '0;
  logic        rd_valid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  tile_t       out_tile;
  logic        out_last;
  logic        busy, done, protocol_err;

  vec_tile_streamer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_buf_id(cmd_buf_id), .cmd_num_tiles(cmd_num_tiles), .rd_en(rd_en),
    .rd_buf_id(rd_buf_id), .rd_tile(rd_tile), .rd_valid(rd_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_tile(out_tile), .out_last(out_last), .busy(busy),
    .done(done), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { tile_t t; logic last; } exp_t;

  int          tests_run = 0, fails = 0, cyc = 0;
  int unsigned seed;
  logic        ready_fixed = 1'b1, rand_mode = 1'b0, inject = 1'b0;
  logic        p0v = 1'b0, p1v = 1'b0;
  tile_t       p0t = '0, p1t = '0;
  int          ctrl_idx = 0;
  buf_id_t     cur_buf = '0;
  exp_t        exp_q[$];
  int          rd_en_cycles[$];
  int          last_idx[$];
  int          rd_en_cnt, ov_cnt, first_ov, lo_cnt, hs_cnt, done_cnt, last_cnt;
  int          done_cyc, last_hs_cyc;
  buf_id_t     first_done_buf;

  function automatic tile_t tile_fn(input int unsigned s, input logic [4:0] b,
                                    input int unsigned idx);
    logic [255:0] v;
    for (int w = 0; w < 8; w++)
      v[w*32 +: 32] = (s + 32'(w) * 32'h9E3779B9) ^ ({27'd0, b} * 32'h01000193) ^
                      (idx * 32'h85EBCA6B) ^ 32'(w);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #1;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Controller model (fixed 2-cycle return latency) plus output scoreboard.
  always @(negedge clk) begin
    rd_valid = p1v | inject;
    rd_tile  = p1t;
    p1v = p0v;
    p1t = p0t;
    p0v = rd_en;
    p0t = tile_fn(seed, rd_buf_id, ctrl_idx);
    if (!rst) begin
      if (rd_en) begin
        ctrl_idx++;
        rd_en_cnt++;
        rd_en_cycles.push_back(cyc);
        chk("rd_buf_id", rd_buf_id, cur_buf);
      end
      if (out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = cyc;
      end
      if (!cmd_ready) lo_cnt++;
      if (out_valid && out_ready) begin
        chk("tile_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_tile", out_tile, e.t);
          chk("out_last", out_last, e.last);
        end
        if (out_last) begin
          last_cnt++;
          last_idx.push_back(hs_cnt);
          last_hs_cyc = cyc;
        end
        hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (done_cnt == 1) first_done_buf = rd_buf_id;
      end
      if (cmd_valid && cmd_ready) begin
        cur_buf  = cmd_buf_id;
        ctrl_idx = 0;
        for (int i = 0; i < int'(cmd_num_tiles); i++) begin
          exp_t e;
          e.t = tile_fn(seed, cmd_buf_id, i);
          e.last = (i == int'(cmd_num_tiles) - 1);
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    rd_en_cnt = 0; ov_cnt = 0; first_ov = -1; lo_cnt = 0; hs_cnt = 0;
    done_cnt = 0; last_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    rd_en_cycles.delete();
    last_idx.delete();
  endtask

  task automatic send_cmd(input logic [4:0] b, input int n);
    int budget = 0;
    cmd_valid = 1'b1;
    cmd_buf_id = b;
    cmd_num_tiles = 16'(n);
    while (!cmd_ready && budget < 200) begin
      step();
      budget++;
    end
    chk("cmd_accept_timeout", budget < 200, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int budget = 0;
    while (done_cnt < target && budget < 2000) begin
      step();
      budget++;
    end
    chk("done_timeout", done_cnt >= target, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int span, lat, budget;
    seed = $urandom;
    clear_stats();
    step(3);
    chk("reset_rd_en", rd_en, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy_done", {busy, done, out_last, protocol_err}, 4'b0);
    chk("reset_rd_buf_id", rd_buf_id, 5'd0);
    chk("reset_out_tile", out_tile, 256'd0);
    rst = 1'b0;
    step(5);

    // 1: basic 3-tile command at full throughput
    clear_stats();
    send_cmd(5'd3, 3);
    wait_done(1);
    step(2);
    chk("t1_rd_en_cnt", rd_en_cnt, 3);
    span = (rd_en_cycles.size() == 3) ? rd_en_cycles[2] - rd_en_cycles[0] : -1;
    chk("t1_rd_en_consecutive", span, 2);
    lat = (rd_en_cycles.size() > 0) ? first_ov - rd_en_cycles[0] : -1;
    chk("t1_first_out_latency", lat, 3);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_done_after_last", done_cyc - last_hs_cyc, 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_exp_empty", exp_q.size(), 0);

    // 2: backpressure limits issues to FIFO credit
    clear_stats();
    ready_fixed = 1'b0;
    send_cmd(5'd7, 8);
    step(15);
    chk("t2_rd_en_stalled", rd_en_cnt, 4);
    chk("t2_out_valid_held", out_valid, 1'b1);
    chk("t2_out_tile_t0", out_tile, tile_fn(seed, 5'd7, 0));
    chk("t2_out_last_t0", out_last, 1'b0);
    ready_fixed = 1'b1;
    wait_done(1);
    chk("t2_rd_en_total", rd_en_cnt, 8);
    chk("t2_hs_cnt", hs_cnt, 8);
    chk("t2_exp_empty", exp_q.size(), 0);
    chk("t2_last_cnt", last_cnt, 1);

    // 3: zero-tile command
    step(2);
    clear_stats();
    send_cmd(5'd9, 0);
    wait_done(1);
    step(3);
    chk("t3_rd_en_cnt", rd_en_cnt, 0);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_out_valid_cnt", ov_cnt, 0);
    chk("t3_cmd_ready_low", (lo_cnt >= 1) && (lo_cnt <= 2), 1'b1);

    // 4: reset mid-command, late returns dropped
    clear_stats();
    send_cmd(5'd4, 6);
    budget = 0;
    while (hs_cnt < 3 && budget < 200) begin
      step();
      budget++;
    end
    chk("t4_three_delivered", hs_cnt >= 3, 1'b1);
    rst = 1'b1;
    #1;
    chk("t4_rst_outputs", {rd_en, out_valid, busy, done, out_last}, 5'b0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step(6);
    chk("t4_no_err_after_rst", protocol_err, 1'b0);
    chk("t4_out_valid_after_rst", out_valid, 1'b0);
    clear_stats();
    send_cmd(5'd5, 2);
    wait_done(1);
    step(2);
    chk("t4_second_hs", hs_cnt, 2);
    chk("t4_exp_empty", exp_q.size(), 0);
    chk("t4_protocol_err", protocol_err, 1'b0);

    // 5: back-to-back commands
    clear_stats();
    send_cmd(5'd1, 2);
    send_cmd(5'd2, 2);
    wait_done(2);
    step(2);
    chk("t5_done_cnt", done_cnt, 2);
    chk("t5_hs_cnt", hs_cnt, 4);
    chk("t5_first_done_buf", first_done_buf, 5'd1);
    chk("t5_last_pos0", (last_idx.size() > 0) ? last_idx[0] : -1, 1);
    chk("t5_last_pos1", (last_idx.size() > 1) ? last_idx[1] : -1, 3);
    chk("t5_exp_empty", exp_q.size(), 0);

    // 6: spurious rd_valid while idle
    clear_stats();
    step(3);
    inject = 1'b1;
    step();
    inject = 1'b0;
    step(3);
    chk("t6_protocol_err", protocol_err, 1'b1);
    chk("t6_no_out_valid", ov_cnt, 0);
    step(10);
    chk("t6_err_sticky", protocol_err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(4);
    chk("t6_err_cleared", protocol_err, 1'b0);

    // randomized commands with random backpressure
    rand_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [4:0] b;
      int n;
      b = 5'($urandom_range(0, 31));
      n = $urandom_range(0, 12);
      clear_stats();
      send_cmd(b, n);
      wait_done(1);
      step(2);
      chk("rnd_hs_cnt", hs_cnt, n);
      chk("rnd_rd_en_cnt", rd_en_cnt, n);
      chk("rnd_exp_empty", exp_q.size(), 0);
      chk("rnd_done_cnt", done_cnt, 1);
      chk("rnd_last_cnt", last_cnt, (n > 0) ? 1 : 0);
    end
    rand_mode = 1'b0;
    chk("rnd_protocol_err", protocol_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
